// File: rtl/bit_serial_adder_if.sv
// ----------------------------------------------------------------------------
// bit_serial_adder_if
//
// Request/result bundle for the bit-serial adder.
//
// Signals:
//   start  request strobe (master -> slave), sampled only when the adder is idle
//   a, b   WIDTH-bit operands (master -> slave), latched on an accepted start
//   cin    carry-in (master -> slave), latched on an accepted start
//   busy   high while bits are being processed (slave -> master)
//   done   one-cycle pulse when sum/cout become valid (slave -> master)
//   sum    registered result (a+b+cin) mod 2^WIDTH (slave -> master)
//   cout   registered carry-out of the MSB (slave -> master)
//
// Modports:
//   master  the requester side (drives start/a/b/cin)
//   slave   the adder side (drives busy/done/sum/cout)
// ----------------------------------------------------------------------------
interface bit_serial_adder_if #(
    parameter int unsigned WIDTH = 4
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output sum,
        output cout
    );

endinterface

// File: rtl/bit_serial_adder.sv
// ----------------------------------------------------------------------------
// bit_serial_adder
//
// LSB-first bit-serial adder. Operands and carry-in are captured on an accepted
// start; one bit is resolved per clock through a single full-adder cell with a
// registered carry. After WIDTH RUN cycles the completed result is copied to
// the held sum/cout outputs and done pulses for one cycle.
//
// Parameters:
//   WIDTH  operand and sum width in bits (1..32)
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  slave side of bit_serial_adder_if
//          start/a/b/cin in, busy/done/sum/cout out
//
// Timing: start sampled at edge k -> busy during cycles k+1..k+WIDTH, done in
// the cycle after edge k+WIDTH. A start seen in the DONE cycle is accepted
// directly, giving one result every WIDTH+1 cycles.
// ----------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    bit_serial_adder_if.slave  bus
);

    // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Single full-adder cell working on the current LSBs and the held carry.
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_shifted;

    always_comb begin
        fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c = (a_sh_q[0] & b_sh_q[0]) |
               (a_sh_q[0] & carry_q)   |
               (b_sh_q[0] & carry_q);
        // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
        // Written as shift/or so WIDTH=1 needs no zero-width slice.
        res_shifted = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                // Both idle states accept a new request; from DONE this gives
                // back-to-back operation without a dead cycle.
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                res_d   = res_shifted;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shifted;
                    cout_d  = fa_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: straight decodes of registered state, so glitch-free
    // ------------------------------------------------------------------------
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Directed bench for bit_serial_adder (WIDTH=4 main instance, WIDTH=1 corner
// instance). Inputs are driven on the falling edge, outputs sampled there too.
// ----------------------------------------------------------------------------
module tb_bit_serial_adder;

    localparam int unsigned W = 4;

    logic clk;
    logic rst;

    int unsigned n_checks;
    int unsigned n_fail;

    bit_serial_adder_if #(.WIDTH(W)) bus_if ();
    bit_serial_adder_if #(.WIDTH(1)) bus1_if ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [32:0] obs,
                            input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge one idle cycle after
    // the done cycle.
    task automatic do_op(input string tag, input logic [3:0] av,
                         input logic [3:0] bv, input logic cv,
                         input logic [3:0] es, input logic ec);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        bus_if.b     = bv;
        bus_if.cin   = cv;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq({tag, "_busy"}, 33'(bus_if.busy), 33'(1'b1));
            check_eq({tag, "_nodone"}, 33'(bus_if.done), 33'(1'b0));
            @(negedge clk);
        end
        check_eq({tag, "_done"}, 33'(bus_if.done), 33'(1'b1));
        check_eq({tag, "_busy_lo"}, 33'(bus_if.busy), 33'(1'b0));
        check_eq({tag, "_sum"}, 33'(bus_if.sum), 33'(es));
        check_eq({tag, "_cout"}, 33'(bus_if.cout), 33'(ec));
        @(negedge clk);
        check_eq({tag, "_done_lo"}, 33'(bus_if.done), 33'(1'b0));
        check_eq({tag, "_sum_hold"}, 33'(bus_if.sum), 33'(es));
    endtask

    initial begin
        int unsigned dones;

        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus_if.start  = 1'b0;
        bus_if.a      = '0;
        bus_if.b      = '0;
        bus_if.cin    = 1'b0;
        bus1_if.start = 1'b0;
        bus1_if.a     = '0;
        bus1_if.b     = '0;
        bus1_if.cin   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 33'(bus_if.busy), 33'(1'b0));
        check_eq("rst_done", 33'(bus_if.done), 33'(1'b0));
        check_eq("rst_sum", 33'(bus_if.sum), 33'(4'b0000));
        check_eq("rst_cout", 33'(bus_if.cout), 33'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        // Basic vectors
        do_op("zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        do_op("v1",   4'b1100, 4'b1001, 1'b0, 4'b0101, 1'b1);
        do_op("v2",   4'b1011, 4'b1000, 1'b0, 4'b0011, 1'b1);
        do_op("v3",   4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0);
        do_op("v4",   4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0);
        do_op("ripple", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
        repeat (2) begin
            check_eq("ripple_idle_sum", 33'(bus_if.sum), 33'(4'b0000));
            check_eq("ripple_idle_cout", 33'(bus_if.cout), 33'(1'b1));
            @(negedge clk);
        end

        // Start during RUN is ignored
        bus_if.start = 1'b1;
        bus_if.a     = 4'b0011;
        bus_if.b     = 4'b0001;
        bus_if.cin   = 1'b0;
        @(negedge clk);                   // RUN cycle 1
        bus_if.start = 1'b0;
        @(negedge clk);                   // RUN cycle 2
        bus_if.start = 1'b1;
        bus_if.a     = 4'b1111;
        bus_if.b     = 4'b1111;
        @(negedge clk);                   // RUN cycle 3
        bus_if.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.done) dones++;
            @(negedge clk);
        end
        check_eq("ign_dones", 33'(dones), 33'(1));
        check_eq("ign_sum", 33'(bus_if.sum), 33'(4'b0100));
        check_eq("ign_cout", 33'(bus_if.cout), 33'(1'b0));

        // Back-to-back with start held high
        bus_if.start = 1'b1;
        bus_if.a     = 4'b0001;
        bus_if.b     = 4'b0001;
        @(negedge clk);                   // RUN cycle 1 of first op
        bus_if.a     = 4'b0010;
        bus_if.b     = 4'b0010;
        check_eq("b2b_busy1", 33'(bus_if.busy), 33'(1'b1));
        repeat (4) @(negedge clk);        // DONE cycle of first op
        check_eq("b2b_done1", 33'(bus_if.done), 33'(1'b1));
        check_eq("b2b_sum1", 33'(bus_if.sum), 33'(4'b0010));
        @(negedge clk);                   // straight into RUN, no gap
        bus_if.start = 1'b0;
        check_eq("b2b_busy2", 33'(bus_if.busy), 33'(1'b1));
        check_eq("b2b_nodone2", 33'(bus_if.done), 33'(1'b0));
        check_eq("b2b_sum_held", 33'(bus_if.sum), 33'(4'b0010));
        repeat (4) @(negedge clk);        // 5 cycles after first done
        check_eq("b2b_done2", 33'(bus_if.done), 33'(1'b1));
        check_eq("b2b_sum2", 33'(bus_if.sum), 33'(4'b0100));
        check_eq("b2b_cout2", 33'(bus_if.cout), 33'(1'b0));
        @(negedge clk);
        check_eq("b2b_idle_done", 33'(bus_if.done), 33'(1'b0));
        check_eq("b2b_idle_busy", 33'(bus_if.busy), 33'(1'b0));

        // Reset mid-operation
        bus_if.start = 1'b1;
        bus_if.a     = 4'b1010;
        bus_if.b     = 4'b0101;
        @(negedge clk);                   // RUN cycle 1
        bus_if.start = 1'b0;
        @(negedge clk);                   // RUN cycle 2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_busy", 33'(bus_if.busy), 33'(1'b0));
        check_eq("mrst_done", 33'(bus_if.done), 33'(1'b0));
        check_eq("mrst_sum", 33'(bus_if.sum), 33'(4'b0000));
        check_eq("mrst_cout", 33'(bus_if.cout), 33'(1'b0));
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus_if.done || bus_if.busy) dones++;
            @(negedge clk);
        end
        check_eq("mrst_quiet", 33'(dones), 33'(0));
        do_op("after_rst", 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0);

        // WIDTH=1 corner: one RUN cycle, 1+1+1 = sum 1, cout 1
        bus1_if.start = 1'b1;
        bus1_if.a     = 1'b1;
        bus1_if.b     = 1'b1;
        bus1_if.cin   = 1'b1;
        @(negedge clk);
        bus1_if.start = 1'b0;
        check_eq("w1_busy", 33'(bus1_if.busy), 33'(1'b1));
        check_eq("w1_nodone", 33'(bus1_if.done), 33'(1'b0));
        @(negedge clk);
        check_eq("w1_done", 33'(bus1_if.done), 33'(1'b1));
        check_eq("w1_sum", 33'(bus1_if.sum), 33'(1'b1));
        check_eq("w1_cout", 33'(bus1_if.cout), 33'(1'b1));
        bus1_if.start = 1'b1;
        bus1_if.a     = 1'b1;
        bus1_if.b     = 1'b0;
        bus1_if.cin   = 1'b0;
        @(negedge clk);
        bus1_if.start = 1'b0;
        @(negedge clk);
        check_eq("w1b_done", 33'(bus1_if.done), 33'(1'b1));
        check_eq("w1b_sum", 33'(bus1_if.sum), 33'(1'b1));
        check_eq("w1b_cout", 33'(bus1_if.cout), 33'(1'b0));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
Sequential, LSB-first bit-serial adder and the additive counterpart of the combinational ripple subtractor. It accepts two WIDTH-bit operands plus carry-in on a start strobe and resolves one bit per clock through a single full-adder cell with a registered carry. It presents a held sum/carry-out and a one-cycle done pulse. It is the area-minimal alternative to the ripple adder/subtractor blocks for slow datapaths.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 1..32)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when idle (state IDLE or DONE)
a  input  WIDTH  operand A; sampled on accepted start
b  input  WIDTH  operand B; sampled on accepted start
cin  input  1  carry-in; sampled on accepted start
busy  output  1  high while bits are being processed (state RUN)
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH
cout  output  1  registered carry-out of the MSB

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, bit counter and carry are cleared. Reset wins over every other input, including in mid-operation. Any in-flight result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1 at edge k: latch a, b and cin into the A/B shift registers and the carry flop, set the bit counter to 0, and go to RUN.
- RUN: busy=1, done=0. At each edge, compute s = A[0]^B[0]^c and c' = maj(A[0],B[0],c). Shift s into the MSB of the result shift register, shift A and B right by 1, set c=c', and increment the counter.
- RUN exit: on the edge where the counter equals WIDTH-1 (edge k+WIDTH), copy the completed result register to sum and c' to cout, then go to DONE.
- start is ignored during RUN. Operands change freely during RUN with no effect.
- DONE: done=1 and busy=0 for exactly one cycle. At the next edge, go to IDLE if start=0. If start=1, accept the new operation as in IDLE and go straight to RUN (back-to-back operation with no dead cycle).
- Latency: start sampled at edge k, busy high during cycles k+1..k+WIDTH, done high during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- sum and cout change only at RUN exit or reset. They hold their value through IDLE, DONE and the next RUN until that run completes.
- Arithmetic: {cout,sum} = a + b + cin computed in WIDTH+1 bits. Overflow wraps, with the carry reported in cout. There is no signed interpretation and no overflow flag.
- WIDTH=1: RUN lasts one cycle, and the sum is produced at edge k+1.

Test Plan:
- Reset, then a=0000, b=0000, cin=0, start one cycle -> busy high 4 cycles, done pulse on the 5th cycle after the start edge, sum=0000, cout=0.
- a=1100, b=1001, cin=0 -> sum=0101, cout=1; a=1011, b=1000 -> sum=0011, cout=1; a=0111, b=0001 -> sum=1000, cout=0; a=1001, b=0110 -> sum=1111, cout=0.
- a=1111, b=0000, cin=1 -> sum=0000, cout=1 (full carry ripple across every bit). Check that sum holds 0000 in the idle cycles that follow.
- Start a=0011, b=0001; pulse start again with a=1111, b=1111 in the 2nd RUN cycle -> second request ignored, result 0100/cout=0, exactly one done pulse.
- Hold start=1 continuously with a=0001, b=0001, then change to a=0010, b=0010 during the first run -> done pulses every 5 cycles with no idle gap. Results 0010 then 0100 (operands taken at the DONE-cycle edge).
- Start a=1010, b=0101; assert rst in the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0000, cout=0, and no done pulse ever appears. A fresh start then completes normally.
